pid_ctrl_param: RTL and testbench

Parametrised, fully pipelined PID controller. It is the successor to the fixed 16-bit pid block and adds the following:
- separate setpoint and measurement inputs
- runtime-programmable fixed-point gains
- valid handshake
- output saturation with status flags
- conditional-integration anti-windup
- synchronous history clear

It sits between the sensor front-end and the actuator driver and accepts one sample per clock.

---
 rtl/pid_ctrl_param.sv | 234 +++++++++++++++++++++++
 tb/tb_pid_ctrl_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: three-stage pipelined PID controller with programmable
// fixed-point gains, output saturation, conditional-integration anti-windup
// and synchronous history clear.
//   stage 0: error e = sp - meas registered with its valid
//   stage 1: integrator / derivative history update, P/I/D products
//   stage 2: sum, floor shift by FRAC, clip to W bits, saturation flags
// Optional build macro PID_DFILT_EN adds a first-order IIR filter on the
// error difference feeding the derivative term.
module pid_ctrl_param #(
  parameter int W        = 16,
  parameter int GW       = 16,
  parameter int FRAC     = 8,
  parameter int IW       = 24,
  parameter int DF_SHIFT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [W-1:0]  sp,
  input  logic [W-1:0]  meas,
  input  logic          in_valid,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  output logic [W-1:0]  out,
  output logic          out_valid,
  output logic          sat_hi,
  output logic          sat_lo
);

  // Error, error difference and product/sum widths. Every product fits in SW
  // bits, and so does the three-term sum, so no intermediate can overflow.
  localparam int EW = W + 1;
  localparam int DW = W + 2;
  localparam int SW = IW + GW + 4;

  localparam logic signed [IW:0]   IMAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0]   IMIN = {2'b11, {(IW-1){1'b0}}};
  localparam logic signed [SW-1:0] OMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Reject parameter sets the datapath widths were not sized for.
  if (IW <= W || DF_SHIFT < 0 || FRAC < 0) begin : g_param_check
    $error("pid_ctrl_param: requires IW > W, DF_SHIFT >= 0, FRAC >= 0");
  end

  // Stage 0 state
  logic signed [EW-1:0] e0_q, e0_d;
  logic                 v0_q, v0_d;

  // Stage 1 state
  logic signed [IW-1:0] integ_q, integ_d;
  logic signed [EW-1:0] eprev_q, eprev_d;
  logic signed [SW-1:0] p1_q, p1_d;
  logic signed [SW-1:0] i1_q, i1_d;
  logic signed [SW-1:0] d1_q, d1_d;
  logic                 v1_q, v1_d;

`ifdef PID_DFILT_EN
  logic signed [DW-1:0] df_q, df_d;
  logic signed [DW:0]   df_delta;
  logic signed [DW-1:0] df_nx;
`endif

  // Stage 2 state (drives the outputs directly)
  logic signed [W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                sat_hi_q, sat_hi_d;
  logic                sat_lo_q, sat_lo_d;

  // Stage 1 intermediates
  logic signed [IW:0]   integ_sum;
  logic signed [IW-1:0] integ_clip;
  logic signed [IW-1:0] integ_nx;
  logic                 windup_hold;
  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] dterm;
  logic signed [SW-1:0] kp_s, ki_s, kd_s;

  // Stage 2 intermediates
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  // Stage 0: capture the error of each valid sample; clear drops the sample.
  always_comb begin
    e0_d = e0_q;
    v0_d = in_valid;
    if (in_valid) begin
      e0_d = EW'($signed(sp)) - EW'($signed(meas));
    end
    if (clear) begin
      e0_d = '0;
      v0_d = 1'b0;
    end
  end

  // Stage 1: integrator with anti-windup, derivative history and products.
  always_comb begin
    kp_s = SW'(kp);
    ki_s = SW'(ki);
    kd_s = SW'(kd);

    integ_sum = (IW+1)'(integ_q) + (IW+1)'(e0_q);
    if (integ_sum > IMAX) begin
      integ_clip = IMAX[IW-1:0];
    end else if (integ_sum < IMIN) begin
      integ_clip = IMIN[IW-1:0];
    end else begin
      integ_clip = integ_sum[IW-1:0];
    end

    // Flags come from the last registered output, so the decision lags the
    // pipeline by design when samples arrive back to back.
    windup_hold = (sat_hi_q && (e0_q > 0)) || (sat_lo_q && (e0_q < 0));
    integ_nx    = windup_hold ? integ_q : integ_clip;

    diff = DW'(e0_q) - DW'(eprev_q);
`ifdef PID_DFILT_EN
    df_delta = (DW+1)'(diff) - (DW+1)'(df_q);
    df_nx    = df_q + DW'(df_delta >>> DF_SHIFT);
    dterm    = df_nx;
    df_d     = df_q;
`else
    dterm    = diff;
`endif

    integ_d = integ_q;
    eprev_d = eprev_q;
    p1_d    = p1_q;
    i1_d    = i1_q;
    d1_d    = d1_q;
    v1_d    = v0_q;

    if (v0_q) begin
      integ_d = integ_nx;
      eprev_d = e0_q;
      p1_d    = SW'(e0_q) * kp_s;
      i1_d    = SW'(integ_nx) * ki_s;
      d1_d    = SW'(dterm) * kd_s;
`ifdef PID_DFILT_EN
      df_d    = df_nx;
`endif
    end

    if (clear) begin
      integ_d = '0;
      eprev_d = '0;
      p1_d    = '0;
      i1_d    = '0;
      d1_d    = '0;
      v1_d    = 1'b0;
`ifdef PID_DFILT_EN
      df_d    = '0;
`endif
    end
  end

  // Stage 2: sum, floor-shift to integer scale, clip to W bits and flag.
  always_comb begin
    sum     = p1_q + i1_q + d1_q;
    shifted = sum >>> FRAC;

    out_d       = out_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    out_valid_d = v1_q;

    if (v1_q) begin
      if (shifted > OMAX) begin
        out_d    = OMAX[W-1:0];
        sat_hi_d = 1'b1;
        sat_lo_d = 1'b0;
      end else if (shifted < OMIN) begin
        out_d    = OMIN[W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b1;
      end else begin
        out_d    = shifted[W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
      end
    end

    if (clear) begin
      out_d       = '0;
      sat_hi_d    = 1'b0;
      sat_lo_d    = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q        <= '0;
      v0_q        <= 1'b0;
      integ_q     <= '0;
      eprev_q     <= '0;
      p1_q        <= '0;
      i1_q        <= '0;
      d1_q        <= '0;
      v1_q        <= 1'b0;
`ifdef PID_DFILT_EN
      df_q        <= '0;
`endif
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
    end else begin
      e0_q        <= e0_d;
      v0_q        <= v0_d;
      integ_q     <= integ_d;
      eprev_q     <= eprev_d;
      p1_q        <= p1_d;
      i1_q        <= i1_d;
      d1_q        <= d1_d;
      v1_q        <= v1_d;
`ifdef PID_DFILT_EN
      df_q        <= df_d;
`endif
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed self-checking bench for pid_ctrl_param in its
// default build (derivative filter disabled). Inputs change on the falling
// edge; outputs are sampled on the falling edge.
module tb_pid_ctrl_param;

  localparam int W  = 16;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [W-1:0]  sp;
  logic [W-1:0]  meas;
  logic          in_valid;
  logic [GW-1:0] kp;
  logic [GW-1:0] ki;
  logic [GW-1:0] kd;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          sat_hi;
  logic          sat_lo;

  int checks   = 0;
  int failures = 0;

  pid_ctrl_param #(
    .W(W), .GW(GW), .FRAC(8), .IW(24), .DF_SHIFT(2)
  ) u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .sp(sp), .meas(meas), .in_valid(in_valid),
    .kp(kp), .ki(ki), .kd(kd),
    .out(out), .out_valid(out_valid), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int s, input int m);
    sp       = W'(s);
    meas     = W'(m);
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    clear    = 1'b0;
  endtask

  // One isolated sample: checks latency, the result and that it holds.
  task automatic one_shot(input string tag, input int s, input int m,
                          input int exp_out, input int exp_hi, input int exp_lo);
    drive(s, m);
    tick();
    in_valid = 1'b0;
    tick();
    check_val({tag, "_early"}, longint'(out_valid), 0);
    tick();
    check_val({tag, "_valid"}, longint'(out_valid), 1);
    check_val({tag, "_out"},   longint'($signed(out)), exp_out);
    check_val({tag, "_hi"},    longint'(sat_hi), exp_hi);
    check_val({tag, "_lo"},    longint'(sat_lo), exp_lo);
    tick();
    check_val({tag, "_strobe"}, longint'(out_valid), 0);
    check_val({tag, "_hold"},   longint'($signed(out)), exp_out);
  endtask

  initial begin
    int exp_i [4] = '{10, 20, 30, 40};
    int err_d [4] = '{0, 50, 50, 20};
    int exp_d [4] = '{0, 50, 0, -30};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    sp = '0; meas = '0; kp = '0; ki = '0; kd = '0;
    #12;
    check_val("rst_out",   longint'($signed(out)), 0);
    check_val("rst_valid", longint'(out_valid), 0);
    check_val("rst_hi",    longint'(sat_hi), 0);
    check_val("rst_lo",    longint'(sat_lo), 0);
    tick();
    reset = 1'b1;

    // Proportional only
    kp = 16'd256; ki = '0; kd = '0;
    one_shot("p", 100, 40, 60, 0, 0);

    // Integral only, back-to-back samples
    kp = '0; ki = 16'd256;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) begin
        check_val($sformatf("i_valid%0d", i - 3), longint'(out_valid), 1);
        check_val($sformatf("i_out%0d", i - 3), longint'($signed(out)), exp_i[i-3]);
      end
      if (i < 4) drive(10, 0);
      else       in_valid = 1'b0;
      tick();
    end

    // clear together with in_valid: clear wins, sample dropped
    clear = 1'b1;
    drive(10, 0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check_val("clr_out",   longint'($signed(out)), 0);
    check_val("clr_valid", longint'(out_valid), 0);
    tick(); tick(); tick();
    check_val("clr_drop", longint'(out_valid), 0);
    one_shot("i_after_clr", 10, 0, 10, 0, 0);

    // Derivative only, back-to-back samples
    ki = '0; kd = 16'd256;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) begin
        check_val($sformatf("d_valid%0d", i - 3), longint'(out_valid), 1);
        check_val($sformatf("d_out%0d", i - 3), longint'($signed(out)), exp_d[i-3]);
      end
      if (i < 4) drive(err_d[i], 0);
      else       in_valid = 1'b0;
      tick();
    end

    // Output saturation both ways
    kd = '0; kp = 16'd1024;
    do_clear();
    one_shot("sat_pos", 20000, 0, 32767, 1, 0);
    one_shot("sat_neg", -20000, 0, -32768, 0, 1);

    // Anti-windup with spaced samples
    kp = '0; ki = 16'd256;
    do_clear();
    one_shot("aw1", 32000, 0, 32000, 0, 0);
    one_shot("aw2", 32000, 0, 32767, 1, 0);
    one_shot("aw3", 32000, 0, 32767, 1, 0);
    one_shot("aw4", -32000, 0, 32000, 0, 0);

    // Asynchronous reset while a sample is in flight
    kp = 16'd1024; ki = '0;
    do_clear();
    one_shot("pre_rst", 20000, 0, 32767, 1, 0);
    ki = 16'd256;
    drive(100, 0);
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_out",   longint'($signed(out)), 0);
    check_val("arst_valid", longint'(out_valid), 0);
    check_val("arst_hi",    longint'(sat_hi), 0);
    check_val("arst_lo",    longint'(sat_lo), 0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check_val("arst_drop", longint'(out_valid), 0);
    kp = 16'd256; ki = '0; kd = '0;
    one_shot("post_rst_p", 5, 0, 5, 0, 0);
    kp = '0; ki = 16'd256;
    one_shot("post_rst_i", 5, 0, 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
